// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, opcodes, reset PC.
package instruction_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [OPC_W-1:0] R_TYPE = 6'b000000;
  localparam logic [OPC_W-1:0] ADDI   = 6'b001000;
  localparam logic [OPC_W-1:0] ORI    = 6'b001101;
  localparam logic [OPC_W-1:0] ANDI   = 6'b001100;
  localparam logic [OPC_W-1:0] SLTI   = 6'b001010;
  localparam logic [OPC_W-1:0] LW     = 6'b100011;
  localparam logic [OPC_W-1:0] SW     = 6'b101011;
  localparam logic [OPC_W-1:0] BEQ    = 6'b000100;
  localparam logic [OPC_W-1:0] J      = 6'b000010;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential pc+4.
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_instruction,
  input  logic            i_jump,
  input  logic            i_branch,
  input  logic            i_zero,
  output logic [XLEN-1:0] o_next_pc_c
);

  logic [XLEN-1:0] w_jump_target;
  logic [XLEN-1:0] w_branch_offset;
  logic            w_unused_opcode;

  assign w_jump_target   = {i_pc_plus4[31:28], i_instruction[25:0], 2'b00};
  assign w_branch_offset = {{14{i_instruction[15]}}, i_instruction[15:0], 2'b00};
  // The opcode field is decoded elsewhere; only the immediate/index bits matter here.
  assign w_unused_opcode = &{1'b0, i_instruction[31:26]};

  always_comb begin
    o_next_pc_c = i_pc_plus4;
    if (i_jump) begin
      o_next_pc_c = w_jump_target;
    end else if (i_branch && i_zero) begin
      o_next_pc_c = i_pc_plus4 + w_branch_offset;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD handshake with instruction memory and a request watchdog.
// Optional macro FETCH_COUNT_EN adds a fetch_count output counting accepted instructions.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic        imem_timeout
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned WAIT_W = $clog2(IMEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(IMEM_WAIT_MAX);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc_plus4;
  logic [XLEN-1:0]   r_instruction;
  logic              r_instr_valid;
  logic              r_imem_req;
  logic              r_timeout;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_timeout_nxt;
  logic              w_capture;
  logic              w_accept;
  logic [XLEN-1:0]   w_next_pc;

  next_pc_calc u_next_pc_calc (
    .i_pc_plus4    (r_pc_plus4),
    .i_instruction (r_instruction),
    .i_jump        (Jump),
    .i_branch      (Branch),
    .i_zero        (Zero),
    .o_next_pc_c   (w_next_pc)
  );

  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake strobes and the saturating REQ watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_accept      = 1'b0;
    w_wait_nxt    = '0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (imem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_wait_cnt == WAIT_MAX_C) begin
          w_wait_nxt = r_wait_cnt;
        end else begin
          w_wait_nxt    = w_wait_inc;
          w_timeout_nxt = (w_wait_inc == WAIT_MAX_C);
        end
      end
      HOLD: begin
        if (!stall) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_pc_plus4    <= RESET_PC + 32'd4;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_timeout     <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_pc       <= w_next_pc;
        r_pc_plus4 <= w_next_pc + 32'd4;
      end
      if (w_capture) begin
        r_instruction <= imem_rdata;
      end
      r_instr_valid <= (w_state_nxt == HOLD);
      r_imem_req    <= (w_state_nxt == REQ);
      r_timeout     <= w_timeout_nxt;
      r_wait_cnt    <= w_wait_nxt;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
    end else if (w_accept) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
`endif

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = r_instr_valid;
  assign instruction  = r_instruction;
  assign opcode       = r_instruction[31:26];
  assign pc_plus4     = r_pc_plus4;
  assign imem_timeout = r_timeout;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a protocol-level model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic [31:0] RST_PC_HI = 32'h1000_0010;
  localparam int          WAIT_MAX  = 8;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall      = 1'b0;
  logic        Jump       = 1'b0;
  logic        Branch     = 1'b0;
  logic        Zero       = 1'b0;

  logic        imem_req, hi_imem_req;
  logic [31:0] imem_addr, hi_imem_addr;
  logic        instr_valid, hi_instr_valid;
  logic [31:0] instruction, hi_instruction;
  logic [5:0]  opcode, hi_opcode;
  logic [31:0] pc_plus4, hi_pc_plus4;
  logic        imem_timeout, hi_imem_timeout;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count, hi_fetch_count;
`endif

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instruction(instruction), .opcode(opcode), .pc_plus4(pc_plus4), .stall(stall),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .imem_timeout(imem_timeout)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  instruction_fetch #(.RESET_PC(RST_PC_HI)) u_dut_hi (
    .clk(clk), .reset_n(reset_n), .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(hi_instr_valid),
    .instruction(hi_instruction), .opcode(hi_opcode), .pc_plus4(hi_pc_plus4), .stall(stall),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .imem_timeout(hi_imem_timeout)
`ifdef FETCH_COUNT_EN
    , .fetch_count(hi_fetch_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference next PC computed arithmetically from the ISA rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input bit j, input bit b, input bit z);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = int'(ins & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Protocol-level model: requesting, holding a word, or the one-cycle post-reset gap.
  logic [31:0] m_pc, m_instr, m_cnt;
  bit          m_req, m_valid, m_tmo, m_tmo_n;
  int          m_waits;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = RST_PC; m_instr = '0; m_req = 1'b0; m_valid = 1'b0;
      m_tmo = 1'b0; m_waits = 0; m_cnt = '0;
    end else begin
      m_tmo_n = 1'b0;
      if (m_valid) begin
        if (!stall) begin
          m_pc = model_next(m_pc, m_instr, Jump, Branch, Zero);
          m_valid = 1'b0; m_req = 1'b1; m_cnt = m_cnt + 32'd1;
        end
      end else if (m_req) begin
        if (imem_ready) begin
          m_instr = imem_rdata; m_req = 1'b0; m_valid = 1'b1; m_waits = 0;
        end else if (m_waits < WAIT_MAX) begin
          m_waits++;
          m_tmo_n = (m_waits == WAIT_MAX);
        end
      end else begin
        m_req = 1'b1;
      end
      m_tmo = m_tmo_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req", 32'(imem_req), 32'(m_req));
      cmp("imem_addr", imem_addr, m_pc);
      cmp("instr_valid", 32'(instr_valid), 32'(m_valid));
      cmp("instruction", instruction, m_instr);
      cmp("opcode", 32'(opcode), m_instr >> 26);
      cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
      cmp("imem_timeout", 32'(imem_timeout), 32'(m_tmo));
`ifdef FETCH_COUNT_EN
      cmp("fetch_count", fetch_count, m_cnt);
`endif
    end
  end

  logic [5:0] ops [9];

  function automatic logic [31:0] rand_instr();
    logic [5:0] o;
    o = ops[$urandom_range(8)];
    return {o, 26'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_one(input logic [31:0] word, input bit j, input bit b, input bit z);
    imem_ready = 1'b1; imem_rdata = word; stall = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    step();
    imem_ready = 1'b0; Jump = j; Branch = b; Zero = z;
    step();
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  int drought = 0;
  int rst_cyc = 0;
  logic [31:0] held_instr;

  initial begin
    ops[0] = instruction_fetch_pkg::R_TYPE; ops[1] = instruction_fetch_pkg::ADDI;
    ops[2] = instruction_fetch_pkg::ORI;    ops[3] = instruction_fetch_pkg::ANDI;
    ops[4] = instruction_fetch_pkg::SLTI;   ops[5] = instruction_fetch_pkg::LW;
    ops[6] = instruction_fetch_pkg::SW;     ops[7] = instruction_fetch_pkg::BEQ;
    ops[8] = instruction_fetch_pkg::J;

    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    #1;
    cmp("rst imem_req", 32'(imem_req), 32'd0);
    cmp("rst imem_addr", imem_addr, RST_PC);
    cmp("rst instr_valid", 32'(instr_valid), 32'd0);
    cmp("rst opcode", 32'(opcode), 32'd0);
    cmp("rst timeout", 32'(imem_timeout), 32'd0);
    cmp("rst hi addr", hi_imem_addr, RST_PC_HI);
    step(); step();
    reset_n = 1'b1;
    step();
    cmp("first req", 32'(imem_req), 32'd1);
    cmp("first addr", imem_addr, 32'd0);

    // First fetch and sequential stream at one word per two cycles.
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    cmp("fetch0 valid", 32'(instr_valid), 32'd1);
    cmp("fetch0 opcode", 32'(opcode), 32'(instruction_fetch_pkg::ADDI));
    cmp("fetch0 pc_plus4", pc_plus4, 32'd4);
    cmp("fetch0 req low", 32'(imem_req), 32'd0);
    imem_ready = 1'b0;
    step();
    cmp("seq addr 4", imem_addr, 32'd4);
    cmp("seq valid drop", 32'(instr_valid), 32'd0);
    fetch_one(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cmp("seq addr 8", imem_addr, 32'd8);
    fetch_one(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cmp("seq addr 12", imem_addr, 32'd12);

    // Backward BEQ from pc=8.
    do_reset();
    fetch_one(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    fetch_one(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cmp("beq pc", imem_addr, 32'd8);
    fetch_one(32'h1000_FFFE, 1'b0, 1'b1, 1'b1);
    cmp("beq target", imem_addr, 32'h0000_0004);

    // Jump wins over a taken branch.
    do_reset();
    cmp("hi start", hi_imem_addr, RST_PC_HI);
    fetch_one(32'h0800_0040, 1'b1, 1'b1, 1'b1);
    cmp("jump hi target", hi_imem_addr, 32'h1000_0100);
    cmp("jump lo target", imem_addr, 32'h0000_0100);

    // Stall holds everything; Jump pulses and late ready are ignored.
    held_instr = 32'h8C22_0004;
    imem_ready = 1'b1; imem_rdata = held_instr; stall = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      imem_rdata = $urandom; Jump = k[0]; Branch = 1'b1; Zero = 1'b1;
      step();
      cmp("stall valid", 32'(instr_valid), 32'd1);
      cmp("stall no req", 32'(imem_req), 32'd0);
      cmp("stall addr", imem_addr, 32'h0000_0100);
      cmp("stall instr", instruction, held_instr);
    end
    stall = 1'b0; imem_ready = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    step();
    cmp("stall release addr", imem_addr, 32'h0000_0104);

    // Watchdog: single pulse after IMEM_WAIT_MAX idle REQ cycles.
    for (int k = 1; k <= 12; k++) begin
      step();
      cmp("timeout pulse", 32'(imem_timeout), (k == WAIT_MAX) ? 32'd1 : 32'd0);
      cmp("timeout stays req", 32'(imem_req), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    cmp("midreq rst req", 32'(imem_req), 32'd0);
    cmp("midreq rst addr", imem_addr, RST_PC);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    cmp("rst ignores ready", 32'(instr_valid), 32'd0);
    cmp("rst instr zero", instruction, 32'd0);
    reset_n = 1'b1;
    step();
    cmp("post rst req", 32'(imem_req), 32'd1);
    cmp("post rst valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b0;

    // Randomized traffic with ready droughts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (reset_n == 1'b0) begin
        if (rst_cyc == 0) reset_n = 1'b1;
        else rst_cyc--;
      end else if ($urandom_range(299) == 0) begin
        reset_n = 1'b0;
        rst_cyc = int'($urandom_range(2));
      end
      if (drought > 0) begin
        drought--;
        imem_ready = 1'b0;
      end else if ($urandom_range(49) == 0) begin
        drought = int'($urandom_range(15, 6));
        imem_ready = 1'b0;
      end else begin
        imem_ready = ($urandom_range(9) < 6);
      end
      imem_rdata = rand_instr();
      stall  = ($urandom_range(9) < 3);
      Jump   = ($urandom_range(9) < 2);
      Branch = ($urandom_range(9) < 4);
      Zero   = 1'($urandom_range(1));
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
